// File: rtl/arm_ex_stage_mc_if.sv
// EX-stage bundle between ID/EX, the multi-cycle execute stage and the EX/MEM consumer.
// master = upstream/downstream environment, slave = arm_ex_stage_mc.
interface arm_ex_stage_mc_if #(
    parameter int DATA_W = 32,
    parameter int SB_W   = 16
);
    logic              id_valid;
    logic              ex_ready;
    logic              alu_or_mac;
    logic              mac_sel;
    logic [DATA_W-1:0] mac_op1;
    logic [DATA_W-1:0] mac_op2;
    logic [DATA_W-1:0] mac_acc;
    logic [DATA_W-1:0] alu_out;
    logic [3:0]        alu_cpsr;
    logic [3:0]        cpsr_mask;
    logic              cpsr_we_in;
    logic [31:0]       cpsr_in;
    logic [SB_W-1:0]   sb_in;
    logic              mem_ready;
    logic              exmem_valid;
    logic [DATA_W-1:0] exmem_data_result;
    logic [SB_W-1:0]   exmem_sb;
    logic [31:0]       cpsr_result;
    logic              cpsr_we;

    modport master (
        output id_valid, alu_or_mac, mac_sel, mac_op1, mac_op2, mac_acc, alu_out,
               alu_cpsr, cpsr_mask, cpsr_we_in, cpsr_in, sb_in, mem_ready,
        input  ex_ready, exmem_valid, exmem_data_result, exmem_sb, cpsr_result, cpsr_we
    );

    modport slave (
        input  id_valid, alu_or_mac, mac_sel, mac_op1, mac_op2, mac_acc, alu_out,
               alu_cpsr, cpsr_mask, cpsr_we_in, cpsr_in, sb_in, mem_ready,
        output ex_ready, exmem_valid, exmem_data_result, exmem_sb, cpsr_result, cpsr_we
    );
endinterface

// File: rtl/arm_ex_stage_mc.sv
// ARM execute stage: single-cycle ALU pass-through plus an iterative MUL/MLA unit
// retiring STEP multiplier bits per cycle, feeding a registered EX/MEM output.
module arm_ex_stage_mc #(
    parameter int DATA_W = 32,
    parameter int STEP   = 4,
    parameter int SB_W   = 16
) (
    input logic             clk,
    input logic             rst,
    arm_ex_stage_mc_if.slave bus
);

    localparam int NSTEPS = DATA_W / STEP;
    localparam int CNT_W  = $clog2(NSTEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        WAIT
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] psum;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       cap_cpsr;
    logic [SB_W-1:0]   cap_sb;
    logic              cap_we;

    logic [DATA_W-1:0] out_data;
    logic [SB_W-1:0]   out_sb;
    logic [31:0]       out_cpsr;
    logic              out_valid;
    logic              out_we;

    logic [DATA_W-1:0] pp;
    logic [DATA_W-1:0] mac_sum;
    logic [DATA_W-1:0] mac_res;
    logic              out_free;
    logic              ready;
    logic              xfer;
    logic              last_step;

    logic              ld;
    logic              ld_we;
    logic [DATA_W-1:0] ld_data;
    logic [SB_W-1:0]   ld_sb;
    logic [31:0]       ld_base;
    logic [31:0]       ld_cpsr;
    logic [3:0]        ld_flags;
    logic [3:0]        ld_mask;

    assign out_free  = !out_valid || bus.mem_ready;
    assign ready     = (state == IDLE) && out_free;
    assign xfer      = bus.id_valid && ready;
    assign last_step = (cnt == CNT_W'(NSTEPS - 1));

    // Partial product of the multiplicand with the low STEP multiplier bits;
    // mcand/mplier are pre-shifted each cycle so the weight is implicit.
    always_comb begin
        pp = '0;
        for (int unsigned j = 0; j < STEP; j++) begin
            if (mplier[j]) begin
                pp = pp + (mcand << j);
            end
        end
    end

    assign mac_sum = psum + pp;
    assign mac_res = (state == MUL) ? mac_sum : psum;

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        ld_data   = mac_res;
        ld_sb     = cap_sb;
        ld_we     = cap_we;
        ld_base   = cap_cpsr;
        ld_mask   = 4'b1100;
        ld_flags  = {mac_res[DATA_W-1], (mac_res == '0), cap_cpsr[29:28]};
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (bus.alu_or_mac) begin
                        ld       = 1'b1;
                        ld_data  = bus.alu_out;
                        ld_sb    = bus.sb_in;
                        ld_we    = bus.cpsr_we_in;
                        ld_base  = bus.cpsr_in;
                        ld_mask  = bus.cpsr_mask;
                        ld_flags = bus.alu_cpsr;
                    end else begin
                        state_nxt = MUL;
                    end
                end
            end
            MUL: begin
                if (last_step) begin
                    if (out_free) begin
                        ld        = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (out_free) begin
                    ld        = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        ld_cpsr = {(ld_base[31:28] & ~ld_mask) | (ld_flags & ld_mask), ld_base[27:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            mplier   <= '0;
            psum     <= '0;
            cnt      <= '0;
            cap_cpsr <= '0;
            cap_sb   <= '0;
            cap_we   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer && !bus.alu_or_mac) begin
                        mcand    <= bus.mac_op1;
                        mplier   <= bus.mac_op2;
                        psum     <= bus.mac_sel ? bus.mac_acc : '0;
                        cnt      <= '0;
                        cap_cpsr <= bus.cpsr_in;
                        cap_sb   <= bus.sb_in;
                        cap_we   <= bus.cpsr_we_in;
                    end
                end
                MUL: begin
                    psum   <= mac_sum;
                    mcand  <= mcand << STEP;
                    mplier <= mplier >> STEP;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_we    <= 1'b0;
            out_data  <= '0;
            out_sb    <= '0;
            out_cpsr  <= '0;
        end else begin
            out_we <= ld && ld_we;
            if (ld) begin
                out_valid <= 1'b1;
                out_data  <= ld_data;
                out_sb    <= ld_sb;
                out_cpsr  <= ld_cpsr;
            end else if (bus.mem_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.ex_ready          = ready;
    assign bus.exmem_valid       = out_valid;
    assign bus.exmem_data_result = out_data;
    assign bus.exmem_sb          = out_sb;
    assign bus.cpsr_result       = out_cpsr;
    assign bus.cpsr_we           = out_we;

endmodule

// File: tb/tb_arm_ex_stage_mc.sv
// Scoreboard bench for arm_ex_stage_mc: directed vectors on the default 32/4 build,
// plus random MUL/MLA sweeps on 16/1 and 64/8 builds against a behavioural product.
module tb_arm_ex_stage_mc;

    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;

    arm_ex_stage_mc_if #(.DATA_W(32), .SB_W(16)) bus ();
    arm_ex_stage_mc_if #(.DATA_W(16), .SB_W(8))  b16 ();
    arm_ex_stage_mc_if #(.DATA_W(64), .SB_W(8))  b64 ();

    arm_ex_stage_mc #(.DATA_W(32), .STEP(4), .SB_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    arm_ex_stage_mc #(.DATA_W(16), .STEP(1), .SB_W(8))  dut16 (.clk(clk), .rst(rst), .bus(b16));
    arm_ex_stage_mc #(.DATA_W(64), .STEP(8), .SB_W(8))  dut64 (.clk(clk), .rst(rst), .bus(b64));

    typedef struct {
        bit          alu;
        bit          sel;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] acc;
        logic [31:0] aout;
        logic [3:0]  acpsr;
        logic [3:0]  mask;
        bit          we;
        logic [31:0] cin;
        logic [15:0] sb;
        logic [31:0] exp_d;
        logic [31:0] exp_c;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [15:0] sb;
        logic [31:0] c;
        bit          we;
    } exp_t;

    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Monitor: a result is "new" when valid rises or follows a consumed one.
    bit   pv, pc;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            pv = 1'b0;
            pc = 1'b0;
        end else begin
            if (bus.exmem_valid) begin
                if (!pv || pc) begin
                    chk("expected_pending", q.size() != 0, 1);
                    if (q.size() != 0) chk("cpsr_we_pulse", bus.cpsr_we, q[0].we);
                end else if (q.size() != 0) begin
                    chk("hold_data", bus.exmem_data_result, q[0].d);
                    chk("stall_no_we", bus.cpsr_we, 0);
                end
                if (bus.mem_ready && q.size() != 0) begin
                    e = q.pop_front();
                    chk("result", bus.exmem_data_result, e.d);
                    chk("sideband", bus.exmem_sb, e.sb);
                    chk("cpsr_result", bus.cpsr_result, e.c);
                end
            end
            pv = bus.exmem_valid;
            pc = bus.exmem_valid && bus.mem_ready;
        end
    end

    task automatic issue(input vec_t v, input bit push, output int xfer, output int tries);
        bit rdy;
        bus.alu_or_mac = v.alu;
        bus.mac_sel    = v.sel;
        bus.mac_op1    = v.op1;
        bus.mac_op2    = v.op2;
        bus.mac_acc    = v.acc;
        bus.alu_out    = v.aout;
        bus.alu_cpsr   = v.acpsr;
        bus.cpsr_mask  = v.mask;
        bus.cpsr_we_in = v.we;
        bus.cpsr_in    = v.cin;
        bus.sb_in      = v.sb;
        bus.id_valid   = 1'b1;
        tries = 0;
        forever begin
            @(negedge clk);
            rdy = bus.ex_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            tries++;
            if (tries > 40) begin
                chk("issue_accepted", rdy, 1);
                break;
            end
        end
        bus.id_valid = 1'b0;
        xfer = cyc;
        if (push) q.push_back('{v.exp_d, v.sb, v.exp_c, v.we});
    endtask

    task automatic wait_valid(output int at);
        int n = 0;
        while (!bus.exmem_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("result_arrives", bus.exmem_valid, 1);
        at = cyc;
    endtask

    task automatic sweep16();
        logic [15:0] a, b, c, exp;
        logic [7:0]  s;
        int          lat;
        for (int k = 0; k < 6; k++) begin
            a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); s = 8'($urandom);
            exp = (k % 2 == 1) ? a * b + c : a * b;
            b16.mac_op1 = a; b16.mac_op2 = b; b16.mac_acc = c; b16.sb_in = s;
            b16.mac_sel = (k % 2 == 1);
            b16.id_valid = 1'b1;
            @(posedge clk);
            #1;
            b16.id_valid = 1'b0;
            lat = 1;
            while (!b16.exmem_valid && lat < 200) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk("sweep16_latency", lat, 17);
            chk("sweep16_result", b16.exmem_data_result, exp);
            chk("sweep16_sb", b16.exmem_sb, s);
            chk("sweep16_flags", b16.cpsr_result[31:28], {exp[15], exp == 16'h0, 2'b00});
        end
    endtask

    task automatic sweep64();
        logic [63:0] a, b, c, exp;
        logic [7:0]  s;
        int          lat;
        for (int k = 0; k < 6; k++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
            s = 8'($urandom);
            exp = (k % 2 == 0) ? a * b + c : a * b;
            b64.mac_op1 = a; b64.mac_op2 = b; b64.mac_acc = c; b64.sb_in = s;
            b64.mac_sel = (k % 2 == 0);
            b64.id_valid = 1'b1;
            @(posedge clk);
            #1;
            b64.id_valid = 1'b0;
            lat = 1;
            while (!b64.exmem_valid && lat < 200) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk("sweep64_latency", lat, 9);
            chk("sweep64_result", b64.exmem_data_result, exp);
            chk("sweep64_sb", b64.exmem_sb, s);
            chk("sweep64_flags", b64.cpsr_result[31:28], {exp[63], exp == 64'h0, 2'b00});
        end
    endtask

    initial begin
        vec_t v1, v2, v3, v4, v5, v6, v7, v8;
        int   x1, x2, t, at, n;
        bit   stale;

        // alu sel op1 op2 acc aout acpsr mask we cin sb exp_d exp_c
        v1 = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0000_1234, 4'b0110, 4'b1111, 1'b1,
               32'h9000_00D3, 16'h0001, 32'h0000_1234, 32'h6000_00D3};
        v2 = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1,
               32'h3000_0010, 16'hA5A5, 32'hFFFF_FFFE, 32'hB000_0010};
        v3 = '{1'b0, 1'b1, 32'h3, 32'h5, 32'hFFFF_FFF1, 32'h0, 4'h0, 4'h0, 1'b0,
               32'h8000_0000, 16'h0F0F, 32'h0000_0000, 32'h4000_0000};
        v4 = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 4'b1111, 4'b0011, 1'b1,
               32'h0000_001F, 16'h1234, 32'hDEAD_BEEF, 32'h3000_001F};
        v5 = '{1'b0, 1'b0, 32'h7, 32'h6, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1,
               32'h5000_0000, 16'hBEEF, 32'h0000_002A, 32'h1000_0000};
        v6 = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0000_CAFE, 4'b1000, 4'b1111, 1'b1,
               32'h0000_0000, 16'h00AA, 32'h0000_CAFE, 32'h8000_0000};
        v7 = '{1'b0, 1'b0, 32'h10, 32'h10, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1,
               32'h0000_0000, 16'h0055, 32'h0000_0100, 32'h0000_0000};
        v8 = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0000_5555, 4'b1111, 4'b0000, 1'b0,
               32'h9000_0010, 16'h7777, 32'h0000_5555, 32'h9000_0010};

        n_pass = 0;
        n_total = 0;
        bus.id_valid = 1'b0; bus.alu_or_mac = 1'b0; bus.mac_sel = 1'b0;
        bus.mac_op1 = '0; bus.mac_op2 = '0; bus.mac_acc = '0; bus.alu_out = '0;
        bus.alu_cpsr = '0; bus.cpsr_mask = '0; bus.cpsr_we_in = 1'b0; bus.cpsr_in = '0;
        bus.sb_in = '0; bus.mem_ready = 1'b1;
        b16.id_valid = 1'b0; b16.alu_or_mac = 1'b0; b16.mac_sel = 1'b0;
        b16.mac_op1 = '0; b16.mac_op2 = '0; b16.mac_acc = '0; b16.alu_out = '0;
        b16.alu_cpsr = '0; b16.cpsr_mask = '0; b16.cpsr_we_in = 1'b0; b16.cpsr_in = '0;
        b16.sb_in = '0; b16.mem_ready = 1'b1;
        b64.id_valid = 1'b0; b64.alu_or_mac = 1'b0; b64.mac_sel = 1'b0;
        b64.mac_op1 = '0; b64.mac_op2 = '0; b64.mac_acc = '0; b64.alu_out = '0;
        b64.alu_cpsr = '0; b64.cpsr_mask = '0; b64.cpsr_we_in = 1'b0; b64.cpsr_in = '0;
        b64.sb_in = '0; b64.mem_ready = 1'b1;

        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset_valid", bus.exmem_valid, 0);
        chk("reset_data", bus.exmem_data_result, 0);
        chk("reset_cpsr", bus.cpsr_result, 0);
        chk("reset_cpsr_we", bus.cpsr_we, 0);
        chk("reset_ex_ready", bus.ex_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(v1, 1'b1, x1, t);
        chk("first_edge_transfer", t, 0);
        wait_valid(at);
        chk("alu_latency", at - x1 + 1, 1);

        issue(v2, 1'b1, x1, t);
        wait_valid(at);
        chk("mul_latency", at - x1 + 1, 9);

        issue(v3, 1'b1, x1, t);
        issue(v4, 1'b1, x2, t);
        chk("mac_throughput", x2 - x1, 9);

        // Downstream stalls across MAC completion.
        issue(v5, 1'b1, x1, t);
        bus.mem_ready = 1'b0;
        wait_valid(at);
        chk("stall_mac_latency", at - x1 + 1, 9);
        repeat (5) begin
            @(negedge clk);
            chk("stall_ex_ready", bus.ex_ready, 0);
        end
        @(posedge clk);
        #1 bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset while a result and its cpsr_we pulse are held.
        bus.mem_ready = 1'b0;
        issue(v6, 1'b1, x1, t);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", bus.exmem_valid, 0);
        chk("async_rst_data", bus.exmem_data_result, 0);
        chk("async_rst_sb", bus.exmem_sb, 0);
        chk("async_rst_cpsr", bus.cpsr_result, 0);
        chk("async_rst_cpsr_we", bus.cpsr_we, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.mem_ready = 1'b1;

        // Reset in the middle of a multiply abandons it.
        issue(v7, 1'b0, x1, t);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_mul_rst_idle", bus.ex_ready, 1);
        chk("mid_mul_rst_valid", bus.exmem_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(v8, 1'b1, x1, t);
        chk("first_edge_after_rst", t, 0);
        wait_valid(at);
        chk("alu_latency_after_rst", at - x1 + 1, 1);
        @(posedge clk);
        #1;
        stale = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.exmem_valid) stale = 1'b1;
        end
        chk("no_stale_result", stale, 0);

        sweep16();
        sweep64();

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
